codificador_bcd: RTL and testbench
==================================

# codificador_bcd

Sequential binary-to-BCD encoder for the frequency meter. It takes the binary pulse count latched at the end of each gate window and converts it into five BCD digits with an iterative shift-add-3 (double-dabble) sequence. The digits drive the five digit inputs of the seven-segment decoding stage. Digit code 5'b11111 is the blank code and falls into that stage's default case.

## Interface
Parameters:
- LARGURA, 17: width of the binary count; supported range 1..24.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge
- limpar  in  1  reset, synchronous, active-high; priority over every other input
- iniciar  in  1  start request; sampled only in state OCIOSO
- contagem  in  LARGURA  binary count to convert; sampled on the accepting edge
- ocupado  out  1  conversion in progress
- pronto  out  1  one-cycle pulse; new digits valid
- estouro  out  1  last accepted count exceeded 99999
- reg_5  out  5  ten-thousands digit (BCD 0..9 or 5'b11111 blank)
- reg_4  out  5  thousands digit
- reg_3  out  5  hundreds digit
- reg_2  out  5  tens digit
- reg_1  out  5  units digit

## Operation
- The FSM has three states:
  - OCIOSO: idle.
  - CONVERTE: shifting.
  - CONCLUI: publish the result.
- OCIOSO with iniciar=1 moves to CONVERTE. On that edge the block latches contagem into the binary shift register, clears the 20-bit BCD scratch, loads the bit counter with LARGURA, and latches the overflow flag as (contagem > 99999).
- CONVERTE, each edge, in order:
  - every scratch nibble >= 5 gets +3;
  - {scratch, bin} shifts left by 1;
  - the bit counter decrements.
  - After the LARGURA-th shift, the FSM moves to CONCLUI.
- CONCLUI moves to OCIOSO. On that edge reg_5..reg_1 load the result, estouro loads the latched flag, and pronto is set.
  - No overflow: each reg_x = {1'b0, scratch nibble}.
  - Overflow: all reg_x = 5'b11111.
- pronto clears on the following edge.
- reg_x and estouro hold their values until the next CONCLUI or limpar.
- iniciar in CONVERTE or CONCLUI is ignored, with no queuing. contagem changes after acceptance have no effect.
- Scratch arithmetic is unsigned 4-bit per nibble. Any carry out of the top nibble is discarded; this only occurs with overflow, where the result is replaced by blanks anyway.

## Timing
- Let E0 be the edge that accepts iniciar.
  - Shifts occur on E1..E_LARGURA.
  - Outputs and pronto update on E_(LARGURA+1).
  - pronto is high for exactly one cycle, between E_(LARGURA+1) and E_(LARGURA+2).
  - Default latency is 18 edges.
- ocupado is 1 from E0 through E_(LARGURA+1), and 0 in the pronto cycle.
- Back-to-back: iniciar held high is accepted again on E_(LARGURA+2).
- Reset values after the limpar edge:
  - FSM = OCIOSO;
  - ocupado = 0, pronto = 0, estouro = 0;
  - reg_5..reg_1 = 5'b00000, unless ZERO_BLANK_EN changes this (see Configuration).
- limpar mid-conversion aborts. No pronto is produced, and the outputs take their reset values on that edge.
- limpar and iniciar on the same edge: limpar wins and the request is dropped.

## Configuration
- Macro: ZERO_BLANK_EN.
- Defined: leading-zero blanking is applied at CONCLUI.
  - Every digit above the most significant nonzero digit becomes 5'b11111.
  - reg_1 is never blanked.
  - The reset value becomes reg_5..reg_2 = 5'b11111 and reg_1 = 5'b00000.
  - The overflow result is unaffected (all blank).
- Undefined: all five digits are always shown, with leading zeros.

## Test plan
- limpar, then iniciar with contagem=0 -> pronto rises 18 edges after acceptance; reg_5..reg_1 = 0,0,0,0,0; estouro=0; ocupado high for 18 cycles.
- contagem=12345 -> reg_5..reg_1 = 1,2,3,4,5; pronto high exactly one cycle.
- contagem=99999 -> all digits 9, estouro=0; then contagem=100000 -> all digits 5'b11111, estouro=1.
- iniciar held high, with contagem switching from 321 to 654 at E3 -> first result 0,0,3,2,1; the second conversion is accepted on the pronto cycle and yields 0,0,6,5,4.
- limpar asserted on E5 of a conversion -> no pronto; ocupado=0 and digits = reset values on that edge; a subsequent iniciar converts normally.
- With ZERO_BLANK_EN: contagem=407 -> reg_5..reg_1 = 11111,11111,4,0,7. contagem=0 -> 11111,11111,11111,11111,0.

Source files
------------

// File: rtl/codificador_bcd.sv
// Sequential binary-to-BCD encoder (double-dabble) for the frequency meter.
// Optional macro ZERO_BLANK_EN: blank leading zero digits with code 5'b11111.
module codificador_bcd #(
  parameter int LARGURA = 17
) (
  input  logic               clock,
  input  logic               limpar,
  input  logic               iniciar,
  input  logic [LARGURA-1:0] contagem,
  output logic               ocupado,
  output logic               pronto,
  output logic               estouro,
  output logic [4:0]         reg_5,
  output logic [4:0]         reg_4,
  output logic [4:0]         reg_3,
  output logic [4:0]         reg_2,
  output logic [4:0]         reg_1
);

  localparam logic [4:0] BLANK = 5'b11111;
  localparam int SW = 20 + LARGURA;

`ifdef ZERO_BLANK_EN
  localparam logic [4:0] RST_HI = BLANK;
`else
  localparam logic [4:0] RST_HI = 5'b00000;
`endif

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    CONCLUI
  } estado_t;

  estado_t estado, prox;

  // {scratch[19:0], bin[LARGURA-1:0]} shifted as one word
  logic [SW-1:0] sh;
  logic [19:0]   adj;
  logic [4:0]    cnt;
  logic          est_l;
  logic [4:0]    dig [5];

  always_ff @(posedge clock) begin
    if (limpar) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO:   if (iniciar) prox = CONVERTE;
      CONVERTE: if (cnt == 5'd1) prox = CONCLUI;
      CONCLUI:  prox = OCIOSO;
      default:  prox = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado != OCIOSO);
  end

  always_comb begin
    adj = '0;
    for (int i = 0; i < 5; i++) begin
      if (sh[LARGURA+4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = sh[LARGURA+4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = sh[LARGURA+4*i +: 4];
    end
  end

  always_comb begin
`ifdef ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    for (int i = 0; i < 5; i++)
      dig[i] = {1'b0, sh[LARGURA+4*i +: 4]};
`ifdef ZERO_BLANK_EN
    for (int i = 4; i >= 1; i--) begin
      if (lead && sh[LARGURA+4*i +: 4] == 4'd0)
        dig[i] = BLANK;
      else
        lead = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (limpar) begin
      sh      <= '0;
      cnt     <= '0;
      est_l   <= 1'b0;
      pronto  <= 1'b0;
      estouro <= 1'b0;
      reg_5   <= RST_HI;
      reg_4   <= RST_HI;
      reg_3   <= RST_HI;
      reg_2   <= RST_HI;
      reg_1   <= 5'b00000;
    end else begin
      pronto <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (iniciar) begin
            sh    <= {20'd0, contagem};
            cnt   <= 5'(LARGURA);
            est_l <= ({{(32-LARGURA){1'b0}}, contagem} > 32'd99999);
          end
        end
        CONVERTE: begin
          // top-nibble carry falls off the shift; only happens on overflow
          sh  <= {adj, sh[LARGURA-1:0]} << 1;
          cnt <= cnt - 5'd1;
        end
        CONCLUI: begin
          pronto  <= 1'b1;
          estouro <= est_l;
          if (est_l) begin
            reg_5 <= BLANK;
            reg_4 <= BLANK;
            reg_3 <= BLANK;
            reg_2 <= BLANK;
            reg_1 <= BLANK;
          end else begin
            reg_5 <= dig[4];
            reg_4 <= dig[3];
            reg_3 <= dig[2];
            reg_2 <= dig[1];
            reg_1 <= dig[0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_codificador_bcd.sv
// Directed self-checking bench for codificador_bcd.
// Expectations follow ZERO_BLANK_EN when the bench is built with it.
module tb_codificador_bcd;

  logic        clock = 1'b0;
  logic        limpar = 1'b0;
  logic        iniciar = 1'b0;
  logic [16:0] contagem = '0;
  logic        ocupado, pronto, estouro;
  logic [4:0]  reg_5, reg_4, reg_3, reg_2, reg_1;
  logic [24:0] rd;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] B = 5'b11111;
`ifdef ZERO_BLANK_EN
  localparam logic [24:0] RST_D = {B, B, B, B, 5'd0};
  localparam logic [24:0] EXP_0 = {B, B, B, B, 5'd0};
  localparam logic [24:0] EXP_321 = {B, B, 5'd3, 5'd2, 5'd1};
  localparam logic [24:0] EXP_654 = {B, B, 5'd6, 5'd5, 5'd4};
  localparam logic [24:0] EXP_407 = {B, B, 5'd4, 5'd0, 5'd7};
`else
  localparam logic [24:0] RST_D = 25'd0;
  localparam logic [24:0] EXP_0 = 25'd0;
  localparam logic [24:0] EXP_321 = {5'd0, 5'd0, 5'd3, 5'd2, 5'd1};
  localparam logic [24:0] EXP_654 = {5'd0, 5'd0, 5'd6, 5'd5, 5'd4};
  localparam logic [24:0] EXP_407 = {5'd0, 5'd0, 5'd4, 5'd0, 5'd7};
`endif
  localparam logic [24:0] EXP_12345 = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
  localparam logic [24:0] EXP_99999 = {5'd9, 5'd9, 5'd9, 5'd9, 5'd9};
  localparam logic [24:0] EXP_OVF = {B, B, B, B, B};

  assign rd = {reg_5, reg_4, reg_3, reg_2, reg_1};

  codificador_bcd #(.LARGURA(17)) dut (
    .clock    (clock),
    .limpar   (limpar),
    .iniciar  (iniciar),
    .contagem (contagem),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .estouro  (estouro),
    .reg_5    (reg_5),
    .reg_4    (reg_4),
    .reg_3    (reg_3),
    .reg_2    (reg_2),
    .reg_1    (reg_1)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one request; returns edges to pronto (40 = timed out) and busy cycles
  task automatic run(input logic [16:0] v, output int lat, output int busy);
    iniciar = 1'b1;
    contagem = v;
    tick();
    iniciar = 1'b0;
    busy = ocupado ? 1 : 0;
    lat = 40;
    for (int n = 1; n < 40; n++) begin
      tick();
      if (pronto) begin
        lat = n;
        break;
      end
      if (ocupado) busy++;
    end
  endtask

  task automatic test_reset();
    limpar = 1'b1;
    tick();
    limpar = 1'b0;
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0 || estouro !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b%b%b expected 000", ocupado, pronto, estouro);
    end
    checks++;
    if (rd !== RST_D) begin
      errors++;
      $display("FAIL reset_digits: got %h expected %h", rd, RST_D);
    end
  endtask

  task automatic test_zero();
    int lat, busy;
    run(17'd0, lat, busy);
    checks++;
    if (lat !== 18) begin
      errors++;
      $display("FAIL zero_latency: got %0d expected 18", lat);
    end
    checks++;
    if (busy !== 18) begin
      errors++;
      $display("FAIL zero_busy: got %0d expected 18", busy);
    end
    checks++;
    if (ocupado !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy_in_pronto: got %b expected 0", ocupado);
    end
    checks++;
    if (rd !== EXP_0 || estouro !== 1'b0) begin
      errors++;
      $display("FAIL zero_digits: got %h/%b expected %h/0", rd, estouro, EXP_0);
    end
  endtask

  task automatic test_12345();
    int lat, busy;
    run(17'd12345, lat, busy);
    checks++;
    if (rd !== EXP_12345 || lat !== 18) begin
      errors++;
      $display("FAIL d12345: got %h lat %0d expected %h lat 18", rd, lat, EXP_12345);
    end
    tick();
    checks++;
    if (pronto !== 1'b0) begin
      errors++;
      $display("FAIL pronto_one_cycle: got %b expected 0", pronto);
    end
    checks++;
    if (rd !== EXP_12345) begin
      errors++;
      $display("FAIL d12345_hold: got %h expected %h", rd, EXP_12345);
    end
  endtask

  task automatic test_overflow();
    int lat, busy;
    run(17'd99999, lat, busy);
    checks++;
    if (rd !== EXP_99999 || estouro !== 1'b0) begin
      errors++;
      $display("FAIL d99999: got %h/%b expected %h/0", rd, estouro, EXP_99999);
    end
    run(17'd100000, lat, busy);
    checks++;
    if (rd !== EXP_OVF || estouro !== 1'b1 || lat !== 18) begin
      errors++;
      $display("FAIL d100000: got %h/%b lat %0d expected %h/1 lat 18", rd, estouro, lat, EXP_OVF);
    end
  endtask

  task automatic test_abort();
    int seen;
    iniciar = 1'b1;
    contagem = 17'd12345;
    tick();
    iniciar = 1'b0;
    repeat (4) tick();
    limpar = 1'b1;
    tick();
    limpar = 1'b0;
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0 || estouro !== 1'b0 || rd !== RST_D) begin
      errors++;
      $display("FAIL abort_reset: got %b%b%b %h expected 000 %h", ocupado, pronto, estouro, rd, RST_D);
    end
    seen = 0;
    repeat (25) begin
      tick();
      if (pronto) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_pronto: got %0d pulses expected 0", seen);
    end
    // limpar and iniciar together: request must be dropped
    limpar = 1'b1;
    iniciar = 1'b1;
    tick();
    limpar = 1'b0;
    iniciar = 1'b0;
    tick();
    checks++;
    if (ocupado !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins: got ocupado %b expected 0", ocupado);
    end
  endtask

  task automatic test_after_abort();
    int lat, busy;
    run(17'd407, lat, busy);
    checks++;
    if (rd !== EXP_407 || lat !== 18 || busy !== 18) begin
      errors++;
      $display("FAIL d407: got %h lat %0d busy %0d expected %h 18 18", rd, lat, busy, EXP_407);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    iniciar = 1'b1;
    contagem = 17'd321;
    tick();
    k = 40;
    for (int n = 1; n < 40; n++) begin
      tick();
      if (n == 3) contagem = 17'd654;
      if (pronto) begin
        k = n;
        break;
      end
    end
    checks++;
    if (k !== 18 || rd !== EXP_321) begin
      errors++;
      $display("FAIL b2b_first: got %h lat %0d expected %h lat 18", rd, k, EXP_321);
    end
    tick();
    iniciar = 1'b0;
    checks++;
    if (ocupado !== 1'b1 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got ocupado %b pronto %b expected 1 0", ocupado, pronto);
    end
    k = 40;
    for (int n = 1; n < 40; n++) begin
      tick();
      if (pronto) begin
        k = n;
        break;
      end
    end
    checks++;
    if (k !== 18 || rd !== EXP_654) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d expected %h lat 18", rd, k, EXP_654);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_zero();
    test_12345();
    test_overflow();
    test_abort();
    test_after_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
